// File: rtl/mult_matrix_deskew.sv
// rtl/mult_matrix_deskew.sv - mode-switchable skew/deskew buffer for systolic-array lane streams
// Optional feature: define MATRIX_DESKEW_ZERO_FILL_EN to force invalid stages and output lanes to 0.
module mult_matrix_deskew #(
    parameter int DATA_SIZE = 4,
    parameter int LANES     = 3,
    parameter int CNT_W     = $clog2(LANES*LANES+1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_SIZE*LANES-1:0] input_stream,
    input  logic [LANES-1:0]           in_valid,
    input  logic                       mode,
    input  logic                       out_ready,
    output logic                       in_ready,
    output logic [DATA_SIZE*LANES-1:0] output_stream,
    output logic [LANES-1:0]           out_valid,
    output logic                       busy,
    output logic [CNT_W-1:0]           occupancy
);

    // r_data[lane][stage], stage index 0 is stage 1 (the input stage)
    logic [DATA_SIZE-1:0] r_data [LANES][LANES];
    logic                 r_vld  [LANES][LANES];
    logic                 r_mode_q;
    logic [CNT_W-1:0]     r_occ;

    logic [DATA_SIZE-1:0] w_nd [LANES][LANES];
    logic                 w_nv [LANES][LANES];
    logic                 w_mode_eff;
    logic [CNT_W-1:0]     w_in_pop;
    logic [CNT_W-1:0]     w_out_pop;
    logic [CNT_W-1:0]     w_occ_next;

    // Output tap depth of a lane: deskew delays lane 0 the most, skew delays it the least
    function automatic int tap_depth(input logic m, input int lane);
        return m ? (lane + 1) : (LANES - lane);
    endfunction

    assign in_ready  = out_ready;
    assign busy      = (r_occ != '0);
    assign occupancy = r_occ;

    // A newly loaded mode already governs data accepted on the same edge
    assign w_mode_eff = (r_occ == '0) ? mode : r_mode_q;

    // Next state of every stage; stages past the tap drop their tokens so a
    // later mode change never exposes stale valid bits
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            for (int s = 0; s < LANES; s++) begin
                w_nd[i][s] = '0;
                w_nv[i][s] = 1'b0;
                if (s == 0) begin
                    w_nd[i][s] = input_stream[(LANES-i)*DATA_SIZE-1 -: DATA_SIZE];
                    w_nv[i][s] = in_valid[LANES-1-i];
                end else begin
                    w_nd[i][s] = r_data[i][s-1];
                    w_nv[i][s] = r_vld[i][s-1] & ((s + 1) <= tap_depth(w_mode_eff, i));
                end
`ifdef MATRIX_DESKEW_ZERO_FILL_EN
                if (!w_nv[i][s]) begin
                    w_nd[i][s] = '0;
                end
`endif
            end
        end
    end

    // Select each lane's tap stage onto the packed outputs
    always_comb begin
        output_stream = '0;
        out_valid     = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int s = 0; s < LANES; s++) begin
                if (s == tap_depth(r_mode_q, i) - 1) begin
                    out_valid[LANES-1-i] = r_vld[i][s];
`ifdef MATRIX_DESKEW_ZERO_FILL_EN
                    output_stream[(LANES-i)*DATA_SIZE-1 -: DATA_SIZE] =
                        r_vld[i][s] ? r_data[i][s] : '0;
`else
                    output_stream[(LANES-i)*DATA_SIZE-1 -: DATA_SIZE] = r_data[i][s];
`endif
                end
            end
        end
    end

    // Token accounting: entries join at stage 1, leave at the tap
    always_comb begin
        w_in_pop  = '0;
        w_out_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            w_in_pop  = w_in_pop  + CNT_W'(in_valid[k]);
            w_out_pop = w_out_pop + CNT_W'(out_valid[k]);
        end
        w_occ_next = r_occ + w_in_pop - w_out_pop;
    end

    // Delay lines, mode latch and occupancy; everything freezes when out_ready is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= 1'b0;
            r_occ    <= '0;
            for (int i = 0; i < LANES; i++) begin
                for (int s = 0; s < LANES; s++) begin
                    r_data[i][s] <= '0;
                    r_vld[i][s]  <= 1'b0;
                end
            end
        end else begin
            if (r_occ == '0) begin
                r_mode_q <= mode;
            end
            if (out_ready) begin
                r_occ <= w_occ_next;
                for (int i = 0; i < LANES; i++) begin
                    for (int s = 0; s < LANES; s++) begin
                        r_data[i][s] <= w_nd[i][s];
                        r_vld[i][s]  <= w_nv[i][s];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_matrix_deskew.sv
// tb/tb_mult_matrix_deskew.sv - directed self-checking bench for mult_matrix_deskew
module tb_mult_matrix_deskew;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] input_stream;
    logic [2:0]  in_valid;
    logic        mode;
    logic        out_ready;
    logic        in_ready;
    logic [11:0] output_stream;
    logic [2:0]  out_valid;
    logic        busy;
    logic [3:0]  occupancy;

    int total = 0;
    int bad   = 0;

    mult_matrix_deskew #(.DATA_SIZE(4), .LANES(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_stream  (input_stream),
        .in_valid      (in_valid),
        .mode          (mode),
        .out_ready     (out_ready),
        .in_ready      (in_ready),
        .output_stream (output_stream),
        .out_valid     (out_valid),
        .busy          (busy),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d, input logic [2:0] v);
        input_stream = d;
        in_valid     = v;
        tick();
    endtask

    // Deskew wavefront 1,2,3 realigned into 12'h123 for one cycle
    task automatic run_deskew(input string p);
        send(12'h100, 3'b100);
        chk({p, "_occ1"}, occupancy, 1);
        chk({p, "_ov1"}, out_valid, 3'b000);
        send(12'h020, 3'b010);
        chk({p, "_occ2"}, occupancy, 2);
        send(12'h003, 3'b001);
        chk({p, "_occ3"}, occupancy, 3);
        chk({p, "_ov3"}, out_valid, 3'b111);
        chk({p, "_os3"}, output_stream, 12'h123);
        chk({p, "_busy3"}, busy, 1'b1);
        send(12'h000, 3'b000);
        chk({p, "_ov4"}, out_valid, 3'b000);
        chk({p, "_occ4"}, occupancy, 0);
        chk({p, "_busy4"}, busy, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        input_stream = '0;
        in_valid     = '0;
        mode         = 1'b0;
        out_ready    = 1'b1;
        #1;
        chk("rst_os", output_stream, 12'h000);
        chk("rst_ov", out_valid, 3'b000);
        chk("rst_occ", occupancy, 0);
        chk("rst_busy", busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_deskew("dsk");

        // skew: 12'h456 staggered over three cycles
        mode = 1'b1;
        send(12'h456, 3'b111);
        chk("skw_ov0", out_valid, 3'b100);
        chk("skw_l0", output_stream[11:8], 4'h4);
        chk("skw_occ0", occupancy, 3);
        mode = 1'b0;
        send(12'h000, 3'b000);
        chk("skw_ov1", out_valid, 3'b010);
        chk("skw_l1", output_stream[7:4], 4'h5);
        chk("skw_occ1", occupancy, 2);
        send(12'h000, 3'b000);
        chk("skw_ov2", out_valid, 3'b001);
        chk("skw_l2", output_stream[3:0], 4'h6);
        chk("skw_occ2", occupancy, 1);
        send(12'h000, 3'b000);
        chk("skw_ov3", out_valid, 3'b000);
        chk("skw_busy3", busy, 1'b0);

        // mode lock: mode goes high while two deskew tokens are in flight
        send(12'h100, 3'b100);
        send(12'h020, 3'b010);
        chk("lock_occ2", occupancy, 2);
        mode = 1'b1;
        send(12'h003, 3'b001);
        chk("lock_ov", out_valid, 3'b111);
        chk("lock_os", output_stream, 12'h123);
        send(12'h000, 3'b000);
        chk("lock_occ0", occupancy, 0);
        chk("lock_ov0", out_valid, 3'b000);
        send(12'h456, 3'b111);
        chk("lock_skw_ov", out_valid, 3'b100);
        chk("lock_skw_l0", output_stream[11:8], 4'h4);
        send(12'h000, 3'b000);
        send(12'h000, 3'b000);
        send(12'h000, 3'b000);
        chk("lock_drain", occupancy, 0);
        mode = 1'b0;

        // backpressure: two stalled cycles after the lane-1 token
        send(12'h100, 3'b100);
        send(12'h020, 3'b010);
        out_ready    = 1'b0;
        input_stream = 12'h003;
        in_valid     = 3'b001;
        #1;
        chk("bp_in_ready", in_ready, 1'b0);
        tick();
        chk("bp_occ_s1", occupancy, 2);
        chk("bp_ov_s1", out_valid, 3'b000);
        tick();
        chk("bp_occ_s2", occupancy, 2);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready1", in_ready, 1'b1);
        send(12'h003, 3'b001);
        chk("bp_ov", out_valid, 3'b111);
        chk("bp_os", output_stream, 12'h123);
        chk("bp_occ3", occupancy, 3);
        out_ready = 1'b0;
        send(12'h000, 3'b000);
        chk("bp_hold_ov", out_valid, 3'b111);
        chk("bp_hold_os", output_stream, 12'h123);
        chk("bp_hold_occ", occupancy, 3);
        out_ready = 1'b1;
        send(12'h000, 3'b000);
        chk("bp_ov_end", out_valid, 3'b000);
        chk("bp_occ_end", occupancy, 0);

        // asynchronous reset with three tokens in flight
        send(12'h100, 3'b100);
        send(12'h020, 3'b010);
        send(12'h003, 3'b001);
        chk("rm_occ3", occupancy, 3);
        in_valid = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_os", output_stream, 12'h000);
        chk("rm_ov", out_valid, 3'b000);
        chk("rm_occ", occupancy, 0);
        chk("rm_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        run_deskew("post");

        // bubbles: invalid lanes never count or show up
        for (int k = 0; k < 4; k++) begin
            send(12'hFFF, 3'b000);
            chk("bub_ov", out_valid, 3'b000);
            chk("bub_occ", occupancy, 0);
`ifdef MATRIX_DESKEW_ZERO_FILL_EN
            chk("bub_os", output_stream, 12'h000);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
